set_result_writeback: RTL and testbench
=======================================

// Module: set_result_writeback
// PURPOSE
//   Sits downstream of the setLessThanUnsigned and signed set-less-than units in the execute stage.
//   It selects the active set result, normalises it to 0/1 and tags it with the destination register.
//   Results are buffered in a small FIFO and handed to the register-file write port over a valid/ready handshake.
//   It also exposes the youngest buffered result as a forwarding bypass.
// PARAMETERS
//   DATA_W      32  width of set results and of oData
//   REG_ADDR_W  5   destination register index width
//   DEPTH       2   buffer entries; power of two, >=2
// PORTS
//   iClk        in   1           rising-edge clock, the only clock
//   iRstN       in   1           synchronous active-low reset, sampled on iClk
//   iValid      in   1           upstream result valid this cycle
//   oReady      out  1           buffer can accept; = !full, registered, no combinational path from iReady
//   iSigned     in   1           1: take iSltData, 0: take iSltuData
//   iSltuData   in   DATA_W      unsigned set-less-than result
//   iSltData    in   DATA_W      signed set-less-than result
//   iRd         in   REG_ADDR_W  destination register index
//   oValid      out  1           head entry valid
//   iReady      in   1           write port accepts head entry
//   oData       out  DATA_W      head entry data, zero-extended bit
//   oRd         out  REG_ADDR_W  head entry destination
//   oWrEn       out  1           oValid & iReady (write strobe)
//   oFwdValid   out  1           a buffered entry exists
//   oFwdRd      out  REG_ADDR_W  youngest buffered entry destination
//   oFwdData    out  DATA_W      youngest buffered entry data
//   oCount      out  $clog2(DEPTH)+1  occupied entries
//   oProtErr    out  1           sticky: an accepted selected result had bits [DATA_W-1:1] != 0
// BEHAVIOUR
//   - Reset (iRstN==0 at posedge): count=0, pointers=0, oProtErr=0; all outputs 0, including oReady. oReady rises the first cycle after reset is released.
//   - Accept = iValid & oReady. Push = Accept & (iRd != 0). Pop = oValid & iReady.
//   - An accepted iRd==0 entry is consumed and discarded; it is never buffered and never forwarded.
//   - Stored data is {(DATA_W-1)'b0, sel[0]}. If sel[DATA_W-1:1] != 0 on Accept, oProtErr is set; it clears only on reset.
//   - Latency: entry pushed at edge N -> oValid=1 with its data after edge N (visible in cycle N+1).
//   - Occupancy states, derived from count:
//       EMPTY (0): oValid=0, oData=0, oRd=0, oFwdValid=0.
//       PARTIAL (1..DEPTH-1): push and pop both allowed, same edge.
//       FULL (DEPTH): oReady=0, so no push.
//   - Transitions:
//       Push only: count+1.
//       Pop only: count-1.
//       Push and Pop: count unchanged; head advances, new tail written.
//   - EMPTY with simultaneous Push: entry is not bypassed to oData the same cycle (no fall-through).
//   - Pointers wrap modulo DEPTH. Ordering is strict FIFO.
//   - Forward = the most recently pushed entry still in the buffer. When that entry is popped and the buffer becomes empty, oFwdValid=0 the next cycle.
//   - iSigned, iSltuData, iSltData and iRd are ignored when Accept=0.
//   - Reset mid-operation: all buffered entries are dropped, nothing is written, and oWrEn=0 during reset.
// STRUCTURE
//   - Shared package set_pkg holds: DATA_W, REG_ADDR_W, SET_TRUE=32'h1, SET_FALSE=32'h0.
//   - One sub-module, result_fifo: a DEPTH-entry synchronous FIFO of {rd, data} with push/pop/count/tail-read.
//   - Top level holds: result select/normalise, rd==0 drop, protection flag, handshake glue.
// TESTING
//   1. Reset held 3 cycles with iValid=1 -> all outputs 0; oReady=1 the first cycle after release.
//   2. iSigned=0, iSltuData=1, iRd=5, iReady=1 -> next cycle oValid=1, oData=1, oRd=5, oWrEn=1; then EMPTY.
//   3. iReady=0, push rd=3 (data 1) then rd=4 (data 0) -> oCount=2, oReady=0, oFwdRd=4. Raise iReady -> rd=3 then rd=4 in order.
//   4. FULL with iValid=1 and iReady=1 the same cycle -> one pop, no push. Next cycle oCount=1, oReady=1; the offered entry is held upstream.
//   5. iRd=0 with data 1 -> oReady stays 1, oCount stays 0, oValid stays 0.
//   6. iSigned=1, iSltData=32'h3 -> oData=1, oProtErr=1 and stays 1. Reset mid-stream with 2 entries -> oCount=0, oProtErr=0.

Source files
------------

// File: rtl/set_pkg.sv
// Shared definitions for the set-result writeback slice.
// Holds the default datapath widths, the canonical normalised set values and the
// occupancy classification used by the writeback buffer.
package set_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [31:0] SET_TRUE  = 32'h1;
    localparam logic [31:0] SET_FALSE = 32'h0;

    // Buffer occupancy classes, derived from the entry count.
    typedef enum logic [1:0] {
        OccEmpty   = 2'd0,
        OccPartial = 2'd1,
        OccFull    = 2'd2
    } occ_e;

    function automatic occ_e occ_of(input logic [31:0] count, input int unsigned depth);
        if (count == 32'd0) begin
            return OccEmpty;
        end else if (count >= 32'(depth)) begin
            return OccFull;
        end else begin
            return OccPartial;
        end
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO of {rd, data} writeback entries.
// Ports:
//   clk_i, rst_ni          clock and synchronous active-low reset
//   push_i, wrd_i, wdata_i write a new tail entry (ignored when full)
//   pop_i                  drop the head entry (ignored when empty)
//   head_rd_o/head_data_o  oldest entry (raw storage, caller gates on empty)
//   tail_rd_o/tail_data_o  youngest entry (raw storage, caller gates on empty)
//   count_o, empty_o, full_o  occupancy
module result_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned PtrW      = $clog2(DEPTH),
    localparam int unsigned CntW      = PtrW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] wrd_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  pop_i,
    output logic [REG_ADDR_W-1:0] head_rd_o,
    output logic [DATA_W-1:0]     head_data_o,
    output logic [REG_ADDR_W-1:0] tail_rd_o,
    output logic [DATA_W-1:0]     tail_data_o,
    output logic [CntW-1:0]       count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    logic [REG_ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0]     data_mem_q [DEPTH];

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] tail_idx;
    logic            push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: every read is qualified by the count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            rd_mem_q[wptr_q]   <= wrd_i;
            data_mem_q[wptr_q] <= wdata_i;
        end
    end

    assign tail_idx    = wptr_q - 1'b1;
    assign head_rd_o   = rd_mem_q[rptr_q];
    assign head_data_o = data_mem_q[rptr_q];
    assign tail_rd_o   = rd_mem_q[tail_idx];
    assign tail_data_o = data_mem_q[tail_idx];
    assign count_o     = count_q;

endmodule

// File: rtl/set_result_writeback.sv
// Execute-stage writeback buffer for set-less-than results.
// Selects the signed or unsigned set result, normalises it to 0/1, tags it with
// the destination register and queues it for the register-file write port.
// Ports:
//   iClk, iRstN                  clock and synchronous active-low reset
//   iValid/oReady                upstream handshake (oReady registered = !full)
//   iSigned, iSltuData, iSltData result select and the two candidate results
//   iRd                          destination register (0 = discard)
//   oValid/iReady, oData, oRd    head entry towards the write port
//   oWrEn                        write strobe, oValid & iReady
//   oFwdValid, oFwdRd, oFwdData  youngest buffered entry for bypass
//   oCount                       occupied entries
//   oProtErr                     sticky: a selected result was not 0/1
module set_result_writeback
    import set_pkg::*;
#(
    parameter int unsigned DATA_W     = set_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = set_pkg::REG_ADDR_W,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned CntW      = $clog2(DEPTH) + 1
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic                  iSigned,
    input  logic [DATA_W-1:0]     iSltuData,
    input  logic [DATA_W-1:0]     iSltData,
    input  logic [REG_ADDR_W-1:0] iRd,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [DATA_W-1:0]     oData,
    output logic [REG_ADDR_W-1:0] oRd,
    output logic                  oWrEn,
    output logic                  oFwdValid,
    output logic [REG_ADDR_W-1:0] oFwdRd,
    output logic [DATA_W-1:0]     oFwdData,
    output logic [CntW-1:0]       oCount,
    output logic                  oProtErr
);

    logic                  ready_q, ready_d;
    logic                  prot_q, prot_d;
    logic [DATA_W-1:0]     sel;
    logic [DATA_W-1:0]     norm;
    logic                  accept, push, pop;
    logic [CntW-1:0]       count, count_next;
    logic                  empty, full;
    logic [REG_ADDR_W-1:0] head_rd, tail_rd;
    logic [DATA_W-1:0]     head_data, tail_data;
    occ_e                  occ;

    assign sel    = iSigned ? iSltData : iSltuData;
    assign norm   = sel[0] ? DATA_W'(SET_TRUE) : DATA_W'(SET_FALSE);
    assign accept = iValid & ready_q;
    // Writes to x0 are architecturally void, so they are accepted and dropped.
    assign push   = accept & (iRd != '0);
    assign pop    = oValid & iReady;

    result_fifo #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i       (iClk),
        .rst_ni      (iRstN),
        .push_i      (push),
        .wrd_i       (iRd),
        .wdata_i     (norm),
        .pop_i       (pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .tail_rd_o   (tail_rd),
        .tail_data_o (tail_data),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full)
    );

    assign occ = occ_of(32'(count), DEPTH);

    // Ready is computed from next-cycle occupancy so it can be a flop with no
    // path from iReady.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
        ready_d = (count_next != CntW'(DEPTH));
        prot_d  = prot_q | (accept & (sel[DATA_W-1:1] != '0));
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            ready_q <= 1'b0;
            prot_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            prot_q  <= prot_d;
        end
    end

    always_comb begin
        oValid    = 1'b0;
        oData     = '0;
        oRd       = '0;
        oFwdValid = 1'b0;
        oFwdRd    = '0;
        oFwdData  = '0;
        if (occ != OccEmpty) begin
            oValid    = 1'b1;
            oData     = head_data;
            oRd       = head_rd;
            oFwdValid = 1'b1;
            oFwdRd    = tail_rd;
            oFwdData  = tail_data;
        end
    end

    assign oReady   = ready_q;
    // Entries still buffered while reset is asserted must not reach the register file.
    assign oWrEn    = oValid & iReady & iRstN;
    assign oCount   = count;
    assign oProtErr = prot_q;

    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_set_result_writeback.sv
module tb_set_result_writeback;

    localparam int DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DEPTH = 2;

    logic                  iClk;
    logic                  iRstN;
    logic                  iValid;
    logic                  oReady;
    logic                  iSigned;
    logic [DATA_W-1:0]     iSltuData;
    logic [DATA_W-1:0]     iSltData;
    logic [REG_ADDR_W-1:0] iRd;
    logic                  oValid;
    logic                  iReady;
    logic [DATA_W-1:0]     oData;
    logic [REG_ADDR_W-1:0] oRd;
    logic                  oWrEn;
    logic                  oFwdValid;
    logic [REG_ADDR_W-1:0] oFwdRd;
    logic [DATA_W-1:0]     oFwdData;
    logic [1:0]            oCount;
    logic                  oProtErr;

    set_result_writeback #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH)
    ) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iValid    (iValid),
        .oReady    (oReady),
        .iSigned   (iSigned),
        .iSltuData (iSltuData),
        .iSltData  (iSltData),
        .iRd       (iRd),
        .oValid    (oValid),
        .iReady    (iReady),
        .oData     (oData),
        .oRd       (oRd),
        .oWrEn     (oWrEn),
        .oFwdValid (oFwdValid),
        .oFwdRd    (oFwdRd),
        .oFwdData  (oFwdData),
        .oCount    (oCount),
        .oProtErr  (oProtErr)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Behavioural model: a queue of pending writes plus ready/protection flags.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } ent_t;

    ent_t        q[$];
    logic        m_ready = 1'b0;
    logic        m_prot  = 1'b0;
    logic [31:0] m_sel;
    logic        m_acc;

    always @(posedge iClk) begin
        if (!iRstN) begin
            q.delete();
            m_ready = 1'b0;
            m_prot  = 1'b0;
        end else begin
            m_acc = iValid && m_ready;
            m_sel = iSigned ? iSltData : iSltuData;
            if (q.size() != 0 && iReady) begin
                void'(q.pop_front());
            end
            if (m_acc && iRd != 0) begin
                q.push_back('{rd: iRd, data: {31'b0, m_sel[0]}});
            end
            if (m_acc && m_sel[31:1] != 0) begin
                m_prot = 1'b1;
            end
            m_ready = (q.size() < DEPTH);
        end
    end

    // Hand-computed literal expectations; -1 means "not pinned this cycle".
    int pin_cnt = -1, pin_vld = -1, pin_dat = -1, pin_rd = -1;
    int pin_rdy = -1, pin_prot = -1, pin_frd = -1, pin_wren = -1, pin_fvld = -1;
    logic check_en = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    int          n;
    logic        e_vld;
    logic [31:0] e_dat, e_frd, e_fdat, e_rd;

    always @(negedge iClk) begin
        if (check_en) begin
            n      = q.size();
            e_vld  = (n != 0);
            e_rd   = e_vld ? 32'(q[0].rd) : 32'd0;
            e_dat  = e_vld ? q[0].data : 32'd0;
            e_frd  = e_vld ? 32'(q[n-1].rd) : 32'd0;
            e_fdat = e_vld ? q[n-1].data : 32'd0;
            chk("valid", 32'(oValid), 32'(e_vld));
            chk("data", oData, e_dat);
            chk("rd", 32'(oRd), e_rd);
            chk("wren", 32'(oWrEn), 32'(e_vld && iReady && iRstN));
            chk("fwd_valid", 32'(oFwdValid), 32'(e_vld));
            chk("fwd_rd", 32'(oFwdRd), e_frd);
            chk("fwd_data", oFwdData, e_fdat);
            chk("count", 32'(oCount), 32'(n));
            chk("ready", 32'(oReady), 32'(m_ready));
            chk("prot", 32'(oProtErr), 32'(m_prot));
            if (pin_cnt  >= 0) chk("lit_count", 32'(oCount), 32'(pin_cnt));
            if (pin_vld  >= 0) chk("lit_valid", 32'(oValid), 32'(pin_vld));
            if (pin_dat  >= 0) chk("lit_data", oData, 32'(pin_dat));
            if (pin_rd   >= 0) chk("lit_rd", 32'(oRd), 32'(pin_rd));
            if (pin_rdy  >= 0) chk("lit_ready", 32'(oReady), 32'(pin_rdy));
            if (pin_prot >= 0) chk("lit_prot", 32'(oProtErr), 32'(pin_prot));
            if (pin_frd  >= 0) chk("lit_fwd_rd", 32'(oFwdRd), 32'(pin_frd));
            if (pin_wren >= 0) chk("lit_wren", 32'(oWrEn), 32'(pin_wren));
            if (pin_fvld >= 0) chk("lit_fwd_valid", 32'(oFwdValid), 32'(pin_fvld));
        end
    end

    // Advance past the next rising edge; pins set afterwards apply to the
    // following falling-edge check.
    task automatic cyc();
        @(posedge iClk);
        #1;
        pin_cnt = -1; pin_vld = -1; pin_dat = -1; pin_rd = -1; pin_rdy = -1;
        pin_prot = -1; pin_frd = -1; pin_wren = -1; pin_fvld = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held three edges with iValid high
        iRstN = 1'b0; iValid = 1'b1; iSigned = 1'b0; iSltuData = 32'h1; iSltData = 32'h0;
        iRd = 5'd5; iReady = 1'b1;
        cyc();
        check_en = 1'b1;
        cyc();
        cyc();
        iRstN = 1'b1; iValid = 1'b0;
        pin_cnt = 0; pin_vld = 0; pin_dat = 0; pin_rd = 0; pin_rdy = 0; pin_prot = 0;
        pin_frd = 0; pin_wren = 0; pin_fvld = 0;
        cyc();
        pin_rdy = 1; pin_cnt = 0;

        // 2: single unsigned result straight through
        iValid = 1'b1; iSigned = 1'b0; iSltuData = 32'h1; iRd = 5'd5; iReady = 1'b1;
        cyc();
        iValid = 1'b0;
        pin_vld = 1; pin_dat = 1; pin_rd = 5; pin_wren = 1; pin_cnt = 1; pin_frd = 5;
        cyc();
        pin_cnt = 0; pin_vld = 0; pin_fvld = 0; pin_wren = 0;

        // 3: fill with writes stalled, then drain in order
        iReady = 1'b0; iValid = 1'b1; iSltuData = 32'h1; iRd = 5'd3;
        cyc();
        iSltuData = 32'h0; iRd = 5'd4;
        cyc();
        iValid = 1'b0; iReady = 1'b1;
        pin_cnt = 2; pin_rdy = 0; pin_frd = 4; pin_rd = 3; pin_dat = 1; pin_wren = 1;
        cyc();
        pin_rd = 4; pin_dat = 0; pin_cnt = 1; pin_frd = 4; pin_rdy = 1; pin_wren = 1;
        cyc();
        pin_cnt = 0; pin_vld = 0;

        // 4: offer while full and draining: pop only, offer held upstream
        iReady = 1'b0; iValid = 1'b1; iSltuData = 32'h1; iRd = 5'd6;
        cyc();
        iRd = 5'd7;
        cyc();
        iRd = 5'd9; iReady = 1'b1;
        pin_cnt = 2; pin_rdy = 0;
        cyc();
        pin_cnt = 1; pin_rdy = 1; pin_rd = 7; pin_frd = 7; pin_wren = 1;
        cyc();
        iValid = 1'b0;
        pin_cnt = 1; pin_rd = 9; pin_frd = 9;
        cyc();
        pin_cnt = 0;

        // 5: x0 destination is accepted and dropped
        iValid = 1'b1; iRd = 5'd0; iSltuData = 32'h1; iReady = 1'b1;
        cyc();
        iValid = 1'b0;
        pin_cnt = 0; pin_rdy = 1; pin_vld = 0;
        cyc();
        pin_cnt = 0; pin_vld = 0; pin_fvld = 0;

        // 6: signed path with a malformed result, then reset mid-stream
        iSigned = 1'b1; iSltData = 32'h3; iSltuData = 32'h0; iRd = 5'd8;
        iValid = 1'b1; iReady = 1'b0;
        cyc();
        iSltData = 32'h0; iRd = 5'd10;
        pin_dat = 1; pin_prot = 1; pin_cnt = 1; pin_rd = 8;
        cyc();
        iValid = 1'b0;
        pin_cnt = 2; pin_prot = 1; pin_frd = 10; pin_rd = 8;
        cyc();
        iRstN = 1'b0; iReady = 1'b1;
        pin_prot = 1; pin_cnt = 2; pin_vld = 1; pin_wren = 0;
        cyc();
        iRstN = 1'b1;
        pin_cnt = 0; pin_prot = 0; pin_rdy = 0; pin_vld = 0; pin_wren = 0;
        cyc();
        pin_rdy = 1; pin_cnt = 0;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
